// File: rtl/stopwatch_counter_pkg.sv
// stopwatch_counter_pkg: shared state encoding and digit width for the stopwatch core
package stopwatch_counter_pkg;
  localparam int BCD_W = 4;
  typedef enum logic [1:0] {
    ST_PAUSED = 2'd0,
    ST_RUN    = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;
endpackage

// File: rtl/stopwatch_counter_bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter that wraps MAX -> 00 on inc
module bcd_mod_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             inc,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             at_max
);
  localparam logic [BCD_W-1:0] T_MAX = BCD_W'(MAX / 10);
  localparam logic [BCD_W-1:0] O_MAX = BCD_W'(MAX % 10);
  localparam logic [BCD_W-1:0] NINE  = BCD_W'(9);
  assign at_max = (tens == T_MAX) && (ones == O_MAX);
  always_ff @(posedge clk_in) begin
    if (rst) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      tens <= at_max ? '0 : (ones == NINE) ? tens + 1'b1 : tens;
      ones <= (at_max || ones == NINE) ? '0 : ones + 1'b1;
    end
  end
endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS stopwatch with run/pause/adjust modes driven by sampled divided clocks
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int MAX_MIN = 59,
  parameter int MAX_SEC = 59
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run_clk,
  input  logic             adj_clk,
  input  logic             pause_pulse,
  input  logic             adj,
  input  logic             sel,
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             running,
  output logic             blink,
  output logic             wrap
);
  state_t state, state_nx;
  logic run_prev, adj_prev, run_tick, adj_tick, sec_max, min_max, inc_sec, inc_min;
  // increments follow the state held this cycle, so a coincident pause still counts
  assign run_tick = (state == ST_RUN) && run_clk && !run_prev;
  assign adj_tick = (state == ST_ADJUST) && adj_clk && !adj_prev;
  assign inc_sec  = run_tick || (adj_tick && sel);
  assign inc_min  = (run_tick && sec_max) || (adj_tick && !sel);
  assign running  = state == ST_RUN;
  always_comb begin
    state_nx = adj ? ST_ADJUST :
               (state == ST_ADJUST) ? ST_PAUSED :
               pause_pulse ? ((state == ST_RUN) ? ST_PAUSED : ST_RUN) :
               state;
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= ST_PAUSED;
      run_prev <= 1'b1;
      adj_prev <= 1'b1;
      blink    <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_nx;
      run_prev <= run_clk;
      adj_prev <= adj_clk;
      blink    <= (state_nx == ST_ADJUST) && (blink ^ adj_tick);
      wrap     <= run_tick && sec_max && min_max;
    end
  end
  bcd_mod_counter #(.MAX(MAX_SEC)) u_sec (
    .clk_in(clk_in),
    .rst(rst),
    .inc(inc_sec),
    .tens(sec_tens),
    .ones(sec_ones),
    .at_max(sec_max)
  );
  bcd_mod_counter #(.MAX(MAX_MIN)) u_min (
    .clk_in(clk_in),
    .rst(rst),
    .inc(inc_min),
    .tens(min_tens),
    .ones(min_ones),
    .at_max(min_max)
  );
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: scoreboard bench with a time-arithmetic reference model
module tb_stopwatch_counter;
  localparam int MAX_MIN = 59;
  localparam int MAX_SEC = 59;
  localparam int M_P = 0, M_R = 1, M_A = 2;
  typedef struct {
    int mt, mo, st, so, run, blk, wrp;
  } exp_t;
  logic clk_in = 1'b0, rst = 1'b1, run_clk = 1'b0, adj_clk = 1'b0;
  logic pause_pulse = 1'b0, adj = 1'b0, sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic running, blink, wrap;
  exp_t q[$];
  int checks = 0, errors = 0, wrap_seen = 0;
  int m_min = 0, m_sec = 0, m_mode = M_P, m_blink = 0, m_wrap = 0;
  logic m_rp = 1'b1, m_ap = 1'b1, cur_adj = 1'b0, cur_sel = 1'b0;
  stopwatch_counter #(.MAX_MIN(MAX_MIN), .MAX_SEC(MAX_SEC)) dut (
    .clk_in(clk_in), .rst(rst), .run_clk(run_clk), .adj_clk(adj_clk),
    .pause_pulse(pause_pulse), .adj(adj), .sel(sel),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .blink(blink), .wrap(wrap)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  always @(posedge clk_in) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("min_tens", int'(min_tens), e.mt);
      chk("min_ones", int'(min_ones), e.mo);
      chk("sec_tens", int'(sec_tens), e.st);
      chk("sec_ones", int'(sec_ones), e.so);
      chk("running", int'(running), e.run);
      chk("blink", int'(blink), e.blk);
      chk("wrap", int'(wrap), e.wrp);
      if (wrap === 1'b1) wrap_seen++;
    end
  end
  task automatic step(input logic rc, input logic ac, input logic pp, input logic rs);
    exp_t e;
    int tot, nm;
    logic re, ae;
    run_clk = rc; adj_clk = ac; pause_pulse = pp; rst = rs; adj = cur_adj; sel = cur_sel;
    re = rc && !m_rp;
    ae = ac && !m_ap;
    if (rs) begin
      m_min = 0; m_sec = 0; m_mode = M_P; m_blink = 0; m_wrap = 0; m_rp = 1'b1; m_ap = 1'b1;
    end else begin
      m_wrap = 0;
      if (m_mode == M_R && re) begin
        tot = (m_min * (MAX_SEC + 1) + m_sec + 1) % ((MAX_MIN + 1) * (MAX_SEC + 1));
        m_min = tot / (MAX_SEC + 1);
        m_sec = tot % (MAX_SEC + 1);
        m_wrap = (tot == 0) ? 1 : 0;
      end
      if (m_mode == M_A && ae) begin
        if (cur_sel) m_sec = (m_sec + 1) % (MAX_SEC + 1);
        else m_min = (m_min + 1) % (MAX_MIN + 1);
        m_blink = 1 - m_blink;
      end
      nm = cur_adj ? M_A : (m_mode == M_A) ? M_P : pp ? ((m_mode == M_R) ? M_P : M_R) : m_mode;
      if (nm != M_A) m_blink = 0;
      m_mode = nm;
      m_rp = rc;
      m_ap = ac;
    end
    e.mt = m_min / 10; e.mo = m_min % 10; e.st = m_sec / 10; e.so = m_sec % 10;
    e.run = (m_mode == M_R) ? 1 : 0; e.blk = m_blink; e.wrp = m_wrap;
    q.push_back(e);
    @(posedge clk_in);
    #2;
  endtask
  task automatic run_edges(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask
  task automatic adj_edges(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask
  task automatic expect_time(input string n, input int mm, input int ss);
    chk({n, "_mt"}, int'(min_tens), mm / 10);
    chk({n, "_mo"}, int'(min_ones), mm % 10);
    chk({n, "_st"}, int'(sec_tens), ss / 10);
    chk({n, "_so"}, int'(sec_ones), ss % 10);
  endtask
  initial begin
    int w0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_time("reset", 0, 0);
    chk("reset_running", int'(running), 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    run_edges(60);
    expect_time("run60", 1, 0);
    chk("run60_running", int'(running), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    run_edges(5);
    expect_time("paused", 1, 0);
    chk("paused_running", int'(running), 0);
    cur_adj = 1'b1; cur_sel = 1'b0;
    adj_edges(58);
    cur_sel = 1'b1;
    adj_edges(58);
    expect_time("adj_5958", 59, 58);
    cur_adj = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    w0 = wrap_seen;
    run_edges(1);
    expect_time("pre_wrap", 59, 59);
    run_edges(1);
    expect_time("wrap", 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_pulse_count", wrap_seen - w0, 1);
    cur_adj = 1'b1; cur_sel = 1'b1;
    adj_edges(59);
    expect_time("sec59", 0, 59);
    adj_edges(1);
    expect_time("sec_wrap_nocarry", 0, 0);
    cur_sel = 1'b0;
    adj_edges(59);
    expect_time("min59", 59, 0);
    adj_edges(1);
    expect_time("min_wrap", 0, 0);
    chk("blink_in_adj", int'(blink), 0);
    adj_edges(1);
    chk("blink_toggle", int'(blink), 1);
    cur_adj = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("blink_exit", int'(blink), 0);
    adj_edges(1);
    expect_time("adj_ignored", 1, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    cur_adj = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    adj_edges(59);
    cur_adj = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    run_edges(7);
    expect_time("t5_0007", 0, 7);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    expect_time("t5_0008", 0, 8);
    chk("t5_running", int'(running), 0);
    run_edges(3);
    expect_time("t5_hold", 0, 8);
    cur_adj = 1'b1; cur_sel = 1'b0;
    adj_edges(12);
    cur_sel = 1'b1;
    adj_edges(26);
    expect_time("t6_1234", 12, 34);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    expect_time("t6_rst", 0, 0);
    chk("t6_running", int'(running), 0);
    chk("t6_blink", int'(blink), 0);
    chk("t6_wrap", int'(wrap), 0);
    cur_adj = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) cur_adj = ~cur_adj;
      if ($urandom_range(0, 7) == 0) cur_sel = ~cur_sel;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 499) == 0));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
